// File: rtl/lfsr_keystream_xor_pkg.sv
// Shared types and helpers for the keystream XOR datapath.
//   state_t   : controller states
//   cnt_width : width of the shared warm-up / bit counter
package lfsr_keystream_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WARMUP = 3'd2,
        ACCEPT = 3'd3,
        GEN    = 3'd4,
        OUT    = 3'd5
    } state_t;

    // Counter must hold the larger of DATA_WIDTH and WARMUP_CYCLES.
    function automatic int cnt_width(input int data_width, input int warmup_cycles);
        int m;
        m = (data_width > warmup_cycles) ? data_width : warmup_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lfsr_keystream_xor_if.sv
// Data handshake bundle for lfsr_keystream_xor.
//   din/din_valid/din_ready    : input word, valid/ready
//   dout/dout_valid/dout_ready : output word, valid/ready
//   slave  : the keystream XOR block
//   master : the producer/consumer around it
interface lfsr_keystream_xor_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );
endinterface

// File: rtl/lfsr_keystream_xor.sv
// Controller and datapath around an external Fibonacci LFSR: reloads the seed
// on start, discards WARMUP_CYCLES shifts, then for every accepted word
// collects DATA_WIDTH keystream bits (first bit ends in the MSB) and emits
// din ^ keystream.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : pulse; reload seed and warm up (overrides any other transition)
//   lfsr_load   : LFSR seed-load control
//   lfsr_shift  : LFSR shift control
//   ks_bit      : LFSR output bit, sampled on shift edges
//   busy        : high outside IDLE
//   bus         : din/dout valid/ready handshakes
module lfsr_keystream_xor
    import lfsr_keystream_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic lfsr_load,
    output logic lfsr_shift,
    input  logic ks_bit,
    output logic busy,
    lfsr_keystream_xor_if.slave bus
);

    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH, WARMUP_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_WARMUP = CNT_WIDTH'(WARMUP_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_DATA   = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic [CNT_WIDTH-1:0]  cnt;
    // Only the newest DATA_WIDTH-1 bits are stored; the final word is
    // completed with the live ks_bit on the last GEN cycle.
    logic [DATA_WIDTH-2:0] ks_hist;
    logic [DATA_WIDTH-1:0] ks_next;
    logic [DATA_WIDTH-1:0] din_reg;
    logic [DATA_WIDTH-1:0] dout_reg;

    logic din_ready_d;
    logic dout_valid_d;

    assign ks_next        = {ks_hist, ks_bit};
    assign bus.din_ready  = din_ready_d;
    assign bus.dout_valid = dout_valid_d;
    assign bus.dout       = dout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lfsr_load    = 1'b0;
        lfsr_shift   = 1'b0;
        din_ready_d  = 1'b0;
        dout_valid_d = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                lfsr_load = 1'b1;
                state_nxt = (WARMUP_CYCLES > 0) ? WARMUP : ACCEPT;
            end
            WARMUP: begin
                lfsr_shift = 1'b1;
                if (cnt <= CNT_ONE) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                din_ready_d = 1'b1;
                if (bus.din_valid) state_nxt = GEN;
            end
            GEN: begin
                lfsr_shift = 1'b1;
                if (cnt <= CNT_ONE) state_nxt = OUT;
            end
            OUT: begin
                dout_valid_d = 1'b1;
                if (bus.dout_ready) state_nxt = ACCEPT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (start) state_nxt = LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            ks_hist  <= '0;
            din_reg  <= '0;
            dout_reg <= '0;
        end else if (start) begin
            // Abandon any word in flight; the counter is reloaded in LOAD.
            ks_hist  <= '0;
            din_reg  <= '0;
            dout_reg <= '0;
        end else begin
            case (state)
                IDLE, OUT: begin
                end
                LOAD: begin
                    cnt <= CNT_WARMUP;
                end
                WARMUP: begin
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                end
                ACCEPT: begin
                    if (bus.din_valid) begin
                        din_reg <= bus.din;
                        ks_hist <= '0;
                        cnt     <= CNT_DATA;
                    end
                end
                GEN: begin
                    ks_hist <= ks_next[DATA_WIDTH-2:0];
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) dout_reg <= din_reg ^ ks_next;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_xor.sv
module tb_lfsr_keystream_xor;

    localparam int DW = 8;
    localparam int WU = 16;
    localparam logic [5:0] SEED  = 6'b000001;
    localparam logic [6:0] COEFF = 7'b1100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ks_bit;
    logic lfsr_load, lfsr_shift, busy;

    logic start0 = 1'b0;
    logic lfsr_load0, lfsr_shift0, busy0;

    lfsr_keystream_xor_if #(.DATA_WIDTH(DW)) bus ();
    lfsr_keystream_xor_if #(.DATA_WIDTH(DW)) bus0 ();

    lfsr_keystream_xor #(.DATA_WIDTH(DW), .WARMUP_CYCLES(WU)) dut (
        .clk(clk), .rst(rst), .start(start), .lfsr_load(lfsr_load),
        .lfsr_shift(lfsr_shift), .ks_bit(ks_bit), .busy(busy), .bus(bus)
    );

    lfsr_keystream_xor #(.DATA_WIDTH(DW), .WARMUP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .lfsr_load(lfsr_load0),
        .lfsr_shift(lfsr_shift0), .ks_bit(ks_bit), .busy(busy0), .bus(bus0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Keystream source: constant, fixed pattern, or the real 6-bit LFSR
    typedef enum {KS_CONST, KS_PAT, KS_LFSR} ks_mode_t;
    ks_mode_t   ks_mode  = KS_CONST;
    logic       ks_const = 1'b1;
    logic [7:0] pat      = 8'h00;
    int         pat_base = 0;
    int         shift_total = 0;
    logic [5:0] lfsr_st  = '0;

    always_comb begin
        int idx;
        idx = (shift_total - pat_base) % 8;
        case (ks_mode)
            KS_CONST: ks_bit = ks_const;
            KS_PAT:   ks_bit = pat[7 - idx];
            default:  ks_bit = lfsr_st[5];
        endcase
    end

    always @(posedge clk) begin
        if (lfsr_shift) shift_total <= shift_total + 1;
        if (lfsr_load) lfsr_st <= SEED;
        else if (lfsr_shift) lfsr_st <= {lfsr_st[4:0], ^(lfsr_st & COEFF[6:1])};
    end

    // Golden keystream: word n after a seed load is the LFSR MSB sequence
    // at positions WU+8n .. WU+8n+7, earliest bit in the MSB.
    function automatic logic [7:0] model_word(input int n);
        logic [5:0] s;
        logic [7:0] w;
        s = SEED;
        w = '0;
        for (int i = 0; i < WU + 8 * (n + 1); i++) begin
            if (i >= WU + 8 * n) w = {w[6:0], s[5]};
            s = {s[4:0], ^(s & COEFF[6:1])};
        end
        return w;
    endfunction

    // Compare process: per-cycle control sanity, per-word result, latency and
    // shift count, output stability.
    logic [7:0] exp_q[$];
    logic       pend = 1'b0;
    logic [7:0] pend_exp;
    int         pc_cyc, pc_sh;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_dout;

    always @(negedge clk) begin
        check("ctrl_onehot", 32'($countones({lfsr_load, lfsr_shift, bus.din_ready, bus.dout_valid}) <= 1), 32'd1);
        if (!busy)
            check("idle_quiet", {lfsr_load, lfsr_shift, bus.din_ready, bus.dout_valid, bus.dout}, 32'd0);
        if (rst || start) begin
            pend = 1'b0;
        end else if (bus.din_valid && bus.din_ready) begin
            if (exp_q.size() == 0) flag("hs_expect", "handshake with no expected word");
            else begin
                pend_exp = exp_q.pop_front();
                pend = 1'b1;
                pc_cyc = 0;
                pc_sh = 0;
            end
        end else if (pend) begin
            pc_cyc++;
            if (lfsr_shift) pc_sh++;
            if (bus.dout_valid) begin
                check("word_dout", bus.dout, pend_exp);
                check("word_latency", pc_cyc, DW + 1);
                check("word_shifts", pc_sh, DW);
                pend = 1'b0;
            end else if (pc_cyc > DW + 1) begin
                flag("word_timeout", "dout_valid late");
                pend = 1'b0;
            end
        end else if (bus.dout_valid && !prev_valid) begin
            flag("dout_unexpected", "dout_valid without accepted word");
        end
        if (bus.dout_valid && prev_valid) check("dout_stable", bus.dout, prev_dout);
        prev_valid = bus.dout_valid;
        prev_dout  = bus.dout;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic expect_warmup(input int n);
        int sh;
        sh = 0;
        @(negedge clk);
        check("load_pulse", {lfsr_load, lfsr_shift}, 2'b10);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (lfsr_shift && !lfsr_load) sh++;
        end
        check("warmup_shifts", sh, n);
        @(negedge clk);
        check("ready_after_warmup", {bus.din_ready, lfsr_shift}, 2'b10);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        bit ok;
        ok = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.din = d;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.din_ready) ok = 1;
        end
        if (!ok) flag("send_timeout", "din_ready never rose");
        @(posedge clk); #1 bus.din_valid = 1'b0;
    endtask

    task automatic recv(input int hold, input logic [7:0] lit);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.dout_valid) ok = 1;
        end
        if (!ok) flag("recv_timeout", "dout_valid never rose");
        else check("dout_literal", bus.dout, lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("backpressure_hold", {bus.dout_valid, bus.din_ready, lfsr_shift}, 3'b100);
        end
        @(posedge clk); #1 bus.dout_ready = 1'b1;
        @(posedge clk); #1 bus.dout_ready = 1'b0;
        @(negedge clk);
        check("ready_after_out", {bus.din_ready, bus.dout_valid}, 2'b10);
    endtask

    task automatic async_reset(input string name);
        @(posedge clk); #3 rst = 1'b1;
        #1 check(name, {busy, lfsr_load, lfsr_shift, bus.din_ready, bus.dout_valid, bus.dout}, 32'd0);
        #10 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_after_reset", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.din = '0;  bus.din_valid = 1'b0;  bus.dout_ready = 1'b0;
        bus0.din = '0; bus0.din_valid = 1'b0; bus0.dout_ready = 1'b0;

        @(negedge clk);
        check("reset_outputs", {busy, lfsr_load, lfsr_shift, bus.din_ready, bus.dout_valid, bus.dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        check("model_word0", model_word(0), 8'h4F);
        check("model_word1", model_word(1), 8'h47);

        // Constant keystream 1 then 0, with backpressure on the second word
        ks_mode = KS_CONST; ks_const = 1'b1;
        pulse_start();
        expect_warmup(WU);
        send(8'hA5, 8'hA5 ^ 8'hFF);
        recv(0, 8'h5A);
        ks_const = 1'b0;
        send(8'h3C, 8'h3C);
        recv(5, 8'h3C);

        // Alternating keystream pattern
        ks_mode = KS_PAT; pat = 8'b1010_1010; pat_base = shift_total;
        send(8'hFF, 8'hFF ^ 8'hAA);
        recv(0, 8'h55);

        // Real LFSR: two consecutive words after a fresh seed load
        ks_mode = KS_LFSR;
        pulse_start();
        expect_warmup(WU);
        send(8'h12, 8'h12 ^ model_word(0));
        recv(0, 8'h5D);
        send(8'h34, 8'h34 ^ model_word(1));
        recv(0, 8'h73);

        // start on the 3rd GEN cycle abandons the word and restarts the keystream
        send(8'h77, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        expect_warmup(WU);
        check("abort_dout_cleared", {bus.dout_valid, bus.dout}, 32'd0);
        send(8'h12, 8'h12 ^ model_word(0));
        recv(0, 8'h5D);

        // Reset in the middle of warm-up
        pulse_start();
        repeat (4) @(negedge clk);
        check("busy_in_warmup", {busy, lfsr_shift}, 2'b11);
        async_reset("rst_mid_warmup");

        // Reset while a word is held in OUT
        ks_mode = KS_CONST; ks_const = 1'b1;
        pulse_start();
        expect_warmup(WU);
        send(8'hA5, 8'h5A);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.dout_valid) ok = 1;
        end
        if (!ok) flag("out_timeout", "dout_valid never rose");
        else check("out_before_reset", bus.dout, 8'h5A);
        async_reset("rst_mid_out");

        // Zero warm-up build: LOAD goes straight to ACCEPT
        check("w0_idle", {busy0, lfsr_load0, lfsr_shift0, bus0.din_ready}, 4'b0000);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(negedge clk);
        check("w0_load", {busy0, lfsr_load0, lfsr_shift0, bus0.din_ready}, 4'b1100);
        @(negedge clk);
        check("w0_accept", {busy0, lfsr_load0, lfsr_shift0, bus0.din_ready}, 4'b1001);

        repeat (2) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
